// File: rtl/ex_div_if.sv
// Execute-stage <-> divider handshake bundle: operands/start/annul in, result/ready out.
// The execute stage uses the master modport; the divider uses the slave modport.
interface ex_div_if;
    logic        signed_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    modport master (
        output signed_div, op_a, op_b, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, op_a, op_b, start, annul,
        output result, ready
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; result = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module ex_div (
    input logic      clk_i,
    input logic      reset_i,
    ex_div_if.slave  div_if
);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e      state_q;
    logic [5:0]  count_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        mag_a   = (div_if.signed_div && div_if.op_a[31]) ? (~div_if.op_a + 32'd1) : div_if.op_a;
        mag_b   = (div_if.signed_div && div_if.op_b[31]) ? (~div_if.op_b + 32'd1) : div_if.op_b;
        // Partial remainder shifted left with the next dividend bit; sign of trial picks restore.
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, divisor_q};
        quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            count_q   <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (div_if.start && !div_if.annul) begin
                        if (div_if.op_b == 32'd0) begin
                            state_q <= StByZero;
`ifdef DIV_EARLY_OUT_EN
                        end else if (mag_a < mag_b) begin
                            state_q  <= StEnd;
                            result_q <= {div_if.op_a, 32'd0};
                            ready_q  <= 1'b1;
`endif
                        end else begin
                            state_q   <= StOn;
                            count_q   <= 6'd0;
                            rem_q     <= 32'd0;
                            quo_q     <= mag_a;
                            divisor_q <= mag_b;
                            neg_quo_q <= div_if.signed_div && (div_if.op_a[31] ^ div_if.op_b[31]);
                            neg_rem_q <= div_if.signed_div && div_if.op_a[31];
                        end
                    end
                end
                StByZero: begin
                    state_q  <= StEnd;
                    result_q <= 64'd0;
                    ready_q  <= 1'b1;
                end
                StOn: begin
                    if (div_if.annul) begin
                        state_q  <= StIdle;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end else if (count_q != 6'd32) begin
                        if (!trial[32]) begin
                            rem_q <= trial[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end else begin
                            rem_q <= shifted[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end
                        count_q <= count_q + 6'd1;
                    end else begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                        state_q  <= StEnd;
                    end
                end
                StEnd: begin
                    if (!div_if.start) begin
                        state_q  <= StIdle;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign div_if.result = result_q;
    assign div_if.ready  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: a reference model fills a scoreboard queue at issue time,
// entries are popped and compared when ready rises.
module tb_ex_div;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] sb_q[$];

    ex_div_if dif ();

    ex_div u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .div_if  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mag(input logic sd, input logic [31:0] x);
        return (sd && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        logic [63:0] exp;
        logic eligible;
        exp = model(sd, a, b);
        sb_q.push_back(exp);
        eligible = (b != 32'd0) && (mag(sd, a) < mag(sd, b));
        @(negedge clk);
        dif.signed_div = sd;
        dif.op_a       = a;
        dif.op_b       = b;
        dif.start      = 1'b1;
        @(posedge clk);
        #1;
        // Operands may change after capture without effect.
        dif.op_a = ~a;
        dif.op_b = ~b;
        n = 0;
        while (!dif.ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (b == 32'd0) check_val({tag, "_lat"}, 64'(n), 64'd1);
        else if (eligible) check_val({tag, "_lat"}, 64'(n == 0 || n == 33), 64'd1);
        else check_val({tag, "_lat"}, 64'(n), 64'd33);
        exp = sb_q.pop_front();
        check_val({tag, "_res"}, dif.result, exp);
        @(posedge clk);
        #1;
        check_val({tag, "_hold_rdy"}, 64'(dif.ready), 64'd1);
        check_val({tag, "_hold_res"}, dif.result, exp);
        @(negedge clk);
        dif.start = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_drop_rdy"}, 64'(dif.ready), 64'd0);
        check_val({tag, "_drop_res"}, dif.result, 64'd0);
    endtask

    initial begin
        int seen;
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        dif.signed_div = 1'b0;
        dif.op_a       = 32'd0;
        dif.op_b       = 32'd0;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        #12;
        check_val("rst_rdy", 64'(dif.ready), 64'd0);
        check_val("rst_res", dif.result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        check_val("const_100_7", model(1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero", 1'b0, 32'h0000_1234, 32'd0);
        run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd3);
        run_op("divu_5_9", 1'b0, 32'd5, 32'd9);
        run_op("div_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", i[0], $urandom, $urandom_range(1, 5000));
        end

        // Abort mid-division with start still high: annul takes priority.
        @(negedge clk);
        dif.signed_div = 1'b0;
        dif.op_a       = 32'd100;
        dif.op_b       = 32'd7;
        dif.start      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        dif.annul = 1'b1;
        @(negedge clk);
        dif.annul = 1'b0;
        dif.start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dif.ready) seen++;
        end
        check_val("annul_no_rdy", 64'(seen), 64'd0);
        run_op("after_annul", 1'b0, 32'd9, 32'd3);

        // Asynchronous reset mid-division.
        @(negedge clk);
        dif.op_a  = 32'd1000;
        dif.op_b  = 32'd3;
        dif.start = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("arst_mid_rdy", 64'(dif.ready), 64'd0);
        check_val("arst_mid_res", dif.result, 64'd0);
        @(negedge clk);
        dif.start = 1'b0;
        reset     = 1'b0;
        run_op("after_rst", 1'b0, 32'd50, 32'd6);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        dif.op_a  = 32'd77;
        dif.op_b  = 32'd5;
        dif.start = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        check_val("pre_arst_rdy", 64'(dif.ready), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_end_rdy", 64'(dif.ready), 64'd0);
        check_val("arst_end_res", dif.result, 64'd0);
        @(negedge clk);
        dif.start = 1'b0;
        reset     = 1'b0;
        run_op("final", 1'b1, 32'hFFFF_FF00, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
